// File: rtl/ula_seq_ctrl_if.sv
// Request/response bundle between control logic and ula_seq_ctrl.
// req_use_acc exists only when ULA_SEQ_ACC_EN is defined.
interface ula_seq_ctrl_if #(
   parameter int unsigned WIDTH = 16
);
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic [3:0]       req_s;
   logic             req_m;
   logic             req_c_in;
`ifdef ULA_SEQ_ACC_EN
   logic             req_use_acc;
`endif
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_c_out;
   logic             rsp_a_eq_b;

`ifdef ULA_SEQ_ACC_EN
   modport master (
      output req_valid, req_a, req_b, req_s, req_m, req_c_in, req_use_acc, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_c_out, rsp_a_eq_b
   );
   modport slave (
      input  req_valid, req_a, req_b, req_s, req_m, req_c_in, req_use_acc, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_c_out, rsp_a_eq_b
   );
`else
   modport master (
      output req_valid, req_a, req_b, req_s, req_m, req_c_in, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_c_out, rsp_a_eq_b
   );
   modport slave (
      input  req_valid, req_a, req_b, req_s, req_m, req_c_in, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_c_out, rsp_a_eq_b
   );
`endif
endinterface

// File: rtl/ula_seq_ctrl.sv
// Nibble-serial sequencer driving one external 4-bit 74181-style ALU, LSB nibble first.
// Optional accumulator (A source) enabled by defining ULA_SEQ_ACC_EN.
module ula_seq_ctrl #(
   parameter int unsigned WIDTH = 16
) (
   input  logic          clk,
   input  logic          rst,
   ula_seq_ctrl_if.slave bus,
   output logic          busy,
   output logic [3:0]    alu_a,
   output logic [3:0]    alu_b,
   output logic [3:0]    alu_s,
   output logic          alu_m,
   output logic          alu_c_in,
   input  logic [3:0]    alu_f,
   input  logic          alu_c_out,
   input  logic          alu_a_eq_b
);
   localparam int unsigned Nibbles = WIDTH / 4;
   localparam int unsigned IdxW    = (Nibbles > 1) ? $clog2(Nibbles) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e            state_q, state_d;
   logic [IdxW-1:0]   idx_q, idx_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [3:0]        s_q, s_d;
   logic              m_q, m_d;
   logic              carry_q, carry_d;
   logic              eq_q, eq_d;
   logic [WIDTH-1:0]  result_q, result_d;
`ifdef ULA_SEQ_ACC_EN
   logic [WIDTH-1:0]  acc_q, acc_d;
`endif

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      a_d      = a_q;
      b_d      = b_q;
      s_d      = s_q;
      m_d      = m_q;
      carry_d  = carry_q;
      eq_d     = eq_q;
      result_d = result_q;
`ifdef ULA_SEQ_ACC_EN
      acc_d    = acc_q;
`endif
      alu_a    = 4'b0000;
      alu_b    = 4'b0000;
      alu_s    = 4'b0000;
      alu_m    = 1'b0;
      alu_c_in = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.req_valid) begin
               state_d = StRun;
               idx_d   = '0;
`ifdef ULA_SEQ_ACC_EN
               a_d     = bus.req_use_acc ? acc_q : bus.req_a;
`else
               a_d     = bus.req_a;
`endif
               b_d     = bus.req_b;
               s_d     = bus.req_s;
               m_d     = bus.req_m;
               carry_d = bus.req_c_in;
               eq_d    = 1'b1;
            end
         end
         StRun: begin
            alu_a    = a_q[{idx_q, 2'b00} +: 4];
            alu_b    = b_q[{idx_q, 2'b00} +: 4];
            alu_s    = s_q;
            alu_m    = m_q;
            alu_c_in = carry_q;
            result_d[{idx_q, 2'b00} +: 4] = alu_f;
            carry_d  = alu_c_out;
            eq_d     = eq_q & alu_a_eq_b;
            idx_d    = idx_q + IdxW'(1);
            if (idx_q == IdxW'(Nibbles - 1)) begin
               state_d = StDone;
               idx_d   = '0;
`ifdef ULA_SEQ_ACC_EN
               // Load includes the final nibble written this cycle.
               acc_d   = result_d;
`endif
            end
         end
         StDone: begin
            if (bus.rsp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.req_ready  = (state_q == StIdle);
   assign bus.rsp_valid  = (state_q == StDone);
   assign busy           = (state_q == StRun) || (state_q == StDone);
   assign bus.rsp_result = result_q;
   assign bus.rsp_c_out  = carry_q;
   assign bus.rsp_a_eq_b = eq_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         s_q      <= 4'b0000;
         m_q      <= 1'b0;
         carry_q  <= 1'b0;
         eq_q     <= 1'b0;
         result_q <= '0;
`ifdef ULA_SEQ_ACC_EN
         acc_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         a_q      <= a_d;
         b_q      <= b_d;
         s_q      <= s_d;
         m_q      <= m_d;
         carry_q  <= carry_d;
         eq_q     <= eq_d;
         result_q <= result_d;
`ifdef ULA_SEQ_ACC_EN
         acc_q    <= acc_d;
`endif
      end
   end
endmodule

// File: tb/tb_ula_seq_ctrl.sv
// Self-checking bench for ula_seq_ctrl with a behavioural 74181 model on the ALU side.
// Accumulator scenarios are compiled in when ULA_SEQ_ACC_EN is defined.
module tb_ula_seq_ctrl;
   localparam int unsigned WIDTH   = 16;
   localparam int unsigned NIBBLES = WIDTH / 4;

   logic       clk;
   logic       rst;
   logic       busy;
   logic [3:0] alu_a, alu_b, alu_s, alu_f;
   logic       alu_m, alu_c_in, alu_c_out, alu_a_eq_b;
   logic [4:0] alu_res;

   int errors = 0;
   int checks = 0;
`ifdef ULA_SEQ_ACC_EN
   logic [WIDTH-1:0] acc_model = '0;
`endif

   ula_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

   ula_seq_ctrl #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .busy       (busy),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_s      (alu_s),
      .alu_m      (alu_m),
      .alu_c_in   (alu_c_in),
      .alu_f      (alu_f),
      .alu_c_out  (alu_c_out),
      .alu_a_eq_b (alu_a_eq_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 74181 with active-high data and active-high (added) carry; returns {c_out, f}.
   function automatic logic [4:0] alu181(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] s, input logic m, input logic c);
      logic [3:0] x, y;
      x = 4'h0;
      y = 4'h0;
      if (m) begin
         case (s)
            4'h0: x = ~a;        4'h1: x = ~(a | b);  4'h2: x = ~a & b;    4'h3: x = 4'h0;
            4'h4: x = ~(a & b);  4'h5: x = ~b;        4'h6: x = a ^ b;     4'h7: x = a & ~b;
            4'h8: x = ~a | b;    4'h9: x = ~(a ^ b);  4'hA: x = b;         4'hB: x = a & b;
            4'hC: x = 4'hF;      4'hD: x = a | ~b;    4'hE: x = a | b;     default: x = a;
         endcase
         return {1'b0, x};
      end
      case (s)
         4'h0: begin x = a;          y = 4'h0;     end
         4'h1: begin x = a | b;      y = 4'h0;     end
         4'h2: begin x = a | ~b;     y = 4'h0;     end
         4'h3: begin x = 4'h0;       y = 4'hF;     end
         4'h4: begin x = a;          y = a & ~b;   end
         4'h5: begin x = a | b;      y = a & ~b;   end
         4'h6: begin x = a;          y = ~b;       end
         4'h7: begin x = a & ~b;     y = 4'hF;     end
         4'h8: begin x = a;          y = a & b;    end
         4'h9: begin x = a;          y = b;        end
         4'hA: begin x = a | ~b;     y = a & b;    end
         4'hB: begin x = a & b;      y = 4'hF;     end
         4'hC: begin x = a;          y = a;        end
         4'hD: begin x = a | b;      y = a;        end
         4'hE: begin x = a | ~b;     y = a;        end
         default: begin x = a;       y = 4'hF;     end
      endcase
      return {1'b0, x} + {1'b0, y} + {4'b0000, c};
   endfunction

   always_comb alu_res = alu181(alu_a, alu_b, alu_s, alu_m, alu_c_in);
   assign alu_f      = alu_res[3:0];
   assign alu_c_out  = alu_res[4];
   assign alu_a_eq_b = (alu_a == alu_b);

   // Wide reference: true add/subtract for S=1001/0110, otherwise the nibble-chained composition.
   // Returns {a_eq_b, c_out, result}.
   function automatic logic [WIDTH+1:0] ref_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [3:0] s, input logic m, input logic c);
      logic [WIDTH:0]   wide;
      logic [WIDTH-1:0] res;
      logic [4:0]       nib;
      logic             carry;
      if (!m && s == 4'b1001) begin
         wide = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
         return {a == b, wide};
      end
      if (!m && s == 4'b0110) begin
         wide = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, c};
         return {a == b, wide};
      end
      res   = '0;
      carry = c;
      for (int i = 0; i < NIBBLES; i++) begin
         nib = alu181(a[4*i +: 4], b[4*i +: 4], s, m, carry);
         res[4*i +: 4] = nib[3:0];
         carry = nib[4];
      end
      return {a == b, carry, res};
   endfunction

   task automatic drive_req(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [3:0] s, input logic m, input logic c, input logic use_acc);
      bus.req_a    = a;
      bus.req_b    = b;
      bus.req_s    = s;
      bus.req_m    = m;
      bus.req_c_in = c;
`ifdef ULA_SEQ_ACC_EN
      bus.req_use_acc = use_acc;
`else
      if (use_acc) $display("note: req_use_acc ignored without accumulator");
`endif
   endtask

   // Issues one op from IDLE (caller sits #1 after an edge), waits bounded for the response,
   // records alu_c_in per RUN cycle and completes the handshake.
   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [3:0] s,
                         input logic m, input logic c, input logic use_acc,
                         output logic [WIDTH-1:0] res, output logic cout, output logic eq,
                         output int lat, output logic [31:0] cins);
      drive_req(a, b, s, m, c, use_acc);
      bus.req_valid = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      lat  = 0;
      cins = '0;
      while (!bus.rsp_valid && lat < 20) begin
         cins[lat] = alu_c_in;
         @(posedge clk); #1;
         lat++;
      end
      res  = bus.rsp_result;
      cout = bus.rsp_c_out;
      eq   = bus.rsp_a_eq_b;
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bus.req_ready, bus.rsp_valid, busy, bus.rsp_c_out, bus.rsp_a_eq_b} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 10000",
                  {bus.req_ready, bus.rsp_valid, busy, bus.rsp_c_out, bus.rsp_a_eq_b});
      end
      checks++;
      if (bus.rsp_result !== '0) begin
         errors++;
         $display("FAIL reset_result: got %h expected 0000", bus.rsp_result);
      end
      checks++;
      if ({alu_a, alu_b, alu_s, alu_m, alu_c_in} !== 14'd0) begin
         errors++;
         $display("FAIL reset_alu: got %h expected 0", {alu_a, alu_b, alu_s, alu_m, alu_c_in});
      end
      rst = 1'b0;
`ifdef ULA_SEQ_ACC_EN
      acc_model = '0;
`endif
      @(posedge clk); #1;
   endtask

   task automatic test_add();
      logic [WIDTH-1:0] res; logic co, eq; int lat; logic [31:0] cins;
      run_op(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b0, 1'b0, res, co, eq, lat, cins);
      checks++;
      if (res !== 16'h2233) begin errors++; $display("FAIL add_result: got %h expected 2233", res); end
      checks++;
      if ({co, eq} !== 2'b00) begin errors++; $display("FAIL add_flags: got %b expected 00", {co, eq}); end
      checks++;
      if (lat != NIBBLES) begin
         errors++; $display("FAIL add_latency: got %0d expected %0d edges", lat, NIBBLES);
      end
`ifdef ULA_SEQ_ACC_EN
      acc_model = 16'h2233;
`endif
   endtask

   task automatic test_carry_ripple();
      logic [WIDTH-1:0] res; logic co, eq; int lat; logic [31:0] cins;
      run_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 1'b0, res, co, eq, lat, cins);
      checks++;
      if ({co, res} !== 17'h10000) begin
         errors++; $display("FAIL ripple_result: got %b_%h expected 1_0000", co, res);
      end
      checks++;
      if (cins[3:0] !== 4'b1110) begin
         errors++; $display("FAIL ripple_c_in: got %b expected 1110 (nibble3..0)", cins[3:0]);
      end
`ifdef ULA_SEQ_ACC_EN
      acc_model = 16'h0000;
`endif
   endtask

   task automatic test_subtract();
      logic [WIDTH-1:0] res; logic co, eq; int lat; logic [31:0] cins;
      run_op(16'h5000, 16'h0001, 4'b0110, 1'b0, 1'b1, 1'b0, res, co, eq, lat, cins);
      checks++;
      if ({co, res} !== 17'h14FFF) begin
         errors++; $display("FAIL sub_result: got %b_%h expected 1_4fff", co, res);
      end
`ifdef ULA_SEQ_ACC_EN
      acc_model = 16'h4FFF;
`endif
   endtask

   task automatic test_logic();
      logic [WIDTH-1:0] res; logic co, eq; int lat; logic [31:0] cins;
      run_op(16'hA5A5, 16'hA5A5, 4'b0110, 1'b1, 1'b1, 1'b0, res, co, eq, lat, cins);
      checks++;
      if ({eq, co, res} !== 18'h20000) begin
         errors++; $display("FAIL logic_xor: got eq=%b co=%b %h expected eq=1 co=0 0000", eq, co, res);
      end
`ifdef ULA_SEQ_ACC_EN
      acc_model = 16'h0000;
`endif
   endtask

   task automatic test_backpressure();
      int n;
      drive_req(16'h3C3C, 16'h1111, 4'b1001, 1'b0, 1'b0, 1'b0);
      bus.req_valid = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      n = 0;
      while (!bus.rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
      // Competing request while the response is stalled must be dropped.
      drive_req(16'h0F0F, 16'h0101, 4'b1001, 1'b0, 1'b1, 1'b0);
      bus.req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({bus.rsp_valid, bus.req_ready, bus.rsp_result} !== {2'b10, 16'h4D4D}) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got v=%b r=%b %h expected v=1 r=0 4d4d",
                     i, bus.rsp_valid, bus.req_ready, bus.rsp_result);
         end
         @(posedge clk); #1;
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({busy, bus.rsp_valid, bus.req_ready} !== 3'b001) begin
            errors++;
            $display("FAIL stall_no_queue[%0d]: got busy/v/r=%b expected 001",
                     i, {busy, bus.rsp_valid, bus.req_ready});
         end
         @(posedge clk); #1;
      end
`ifdef ULA_SEQ_ACC_EN
      acc_model = 16'h4D4D;
`endif
   endtask

   task automatic test_reset_mid_run();
      drive_req(16'h1357, 16'h2468, 4'b1001, 1'b0, 1'b0, 1'b0);
      bus.req_valid = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
`ifdef ULA_SEQ_ACC_EN
      acc_model = '0;
`endif
      checks++;
      if ({bus.req_ready, bus.rsp_valid, busy, bus.rsp_result} !== {3'b100, 16'h0000}) begin
         errors++;
         $display("FAIL abort_state: got r/v/busy=%b %h expected 100 0000",
                  {bus.req_ready, bus.rsp_valid, busy}, bus.rsp_result);
      end
      checks++;
      if ({alu_a, alu_b, alu_s, alu_m, alu_c_in} !== 14'd0) begin
         errors++; $display("FAIL abort_alu: got %h expected 0", {alu_a, alu_b, alu_s, alu_m, alu_c_in});
      end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL abort_no_rsp[%0d]: got %b expected 0", i, bus.rsp_valid);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] a, b, a_eff, res; logic [3:0] s; logic m, c, u, co, eq;
      logic [WIDTH+1:0] exp; int lat; logic [31:0] cins, r;
      for (int i = 0; i < 40; i++) begin
         r = $urandom(); a = r[15:0]; b = r[31:16];
         r = $urandom(); s = r[3:0]; m = r[4]; c = r[5]; u = 1'b0;
         if (r[7:6] == 2'b00) b = a;
`ifdef ULA_SEQ_ACC_EN
         u = r[8];
         a_eff = u ? acc_model : a;
`else
         a_eff = a;
`endif
         exp = ref_op(a_eff, b, s, m, c);
         run_op(a, b, s, m, c, u, res, co, eq, lat, cins);
         checks++;
         if ({eq, co, res} !== exp) begin
            errors++;
            $display("FAIL rand_op[%0d] a=%h b=%h s=%h m=%b c=%b: got %b_%b_%h expected %b_%b_%h",
                     i, a_eff, b, s, m, c, eq, co, res, exp[WIDTH+1], exp[WIDTH], exp[WIDTH-1:0]);
         end
         checks++;
         if (lat != NIBBLES || {alu_a, alu_b, alu_s, alu_m, alu_c_in} !== 14'd0) begin
            errors++;
            $display("FAIL rand_timing[%0d]: got lat=%0d alu=%h expected lat=%0d alu=0",
                     i, lat, {alu_a, alu_b, alu_s, alu_m, alu_c_in}, NIBBLES);
         end
`ifdef ULA_SEQ_ACC_EN
         acc_model = exp[WIDTH-1:0];
`endif
      end
   endtask

   task automatic test_back_to_back();
      int accepts[$];
      logic pre;
      int n;
      drive_req(16'h00FF, 16'h0F01, 4'b1001, 1'b0, 1'b0, 1'b0);
      bus.rsp_ready = 1'b1;
      bus.req_valid = 1'b1;
      for (int cyc = 0; cyc < 20; cyc++) begin
         pre = bus.req_ready;
         @(posedge clk); #1;
         if (pre) accepts.push_back(cyc);
         if (bus.rsp_valid) begin
            checks++;
            if (bus.rsp_result !== 16'h1000) begin
               errors++; $display("FAIL b2b_result: got %h expected 1000", bus.rsp_result);
            end
         end
      end
      bus.req_valid = 1'b0;
      n = 0;
      while ((busy || !bus.req_ready) && n < 20) begin @(posedge clk); #1; n++; end
      bus.rsp_ready = 1'b0;
      checks++;
      if (accepts.size() < 3 || n >= 20) begin
         errors++; $display("FAIL b2b_count: got %0d accepts drain=%0d expected >=3 and drained",
                            accepts.size(), n);
      end
      for (int i = 1; i < accepts.size(); i++) begin
         checks++;
         if (accepts[i] - accepts[i-1] != NIBBLES + 2) begin
            errors++; $display("FAIL b2b_interval[%0d]: got %0d expected %0d",
                               i, accepts[i] - accepts[i-1], NIBBLES + 2);
         end
      end
`ifdef ULA_SEQ_ACC_EN
      acc_model = 16'h1000;
`endif
   endtask

`ifdef ULA_SEQ_ACC_EN
   task automatic test_acc();
      logic [WIDTH-1:0] res; logic co, eq; int lat; logic [31:0] cins;
      run_op(16'h0010, 16'h0005, 4'b1001, 1'b0, 1'b0, 1'b0, res, co, eq, lat, cins);
      checks++;
      if (res !== 16'h0015) begin errors++; $display("FAIL acc_load: got %h expected 0015", res); end
      run_op(16'hBEEF, 16'h0001, 4'b1001, 1'b0, 1'b0, 1'b1, res, co, eq, lat, cins);
      checks++;
      if (res !== 16'h0016) begin errors++; $display("FAIL acc_use: got %h expected 0016", res); end
      acc_model = 16'h0016;
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst           = 1'b1;
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b0;
      drive_req('0, '0, 4'h0, 1'b0, 1'b0, 1'b0);
      test_reset();
      test_add();
      test_carry_ripple();
      test_subtract();
      test_logic();
      test_backpressure();
      test_reset_mid_run();
      test_random();
      test_back_to_back();
`ifdef ULA_SEQ_ACC_EN
      test_acc();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ula_seq_ctrl.md
# ula_seq_ctrl

Nibble-serial sequencer that runs WIDTH-bit ALU operations on a single external 4-bit 74181-style ALU. It accepts one wide operation through a valid/ready request port. It then drives the ALU one nibble per cycle, least-significant nibble first, chaining carry between nibbles, and returns the assembled result, final carry and wide equality flag on a valid/ready response port. It sits between the instruction/control logic and the shared 4-bit ALU instance.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 8; NIBBLES = WIDTH/4.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request valid.
- req_ready  out  1  request ready; high only in IDLE.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- req_s  in  4  ALU function select.
- req_m  in  1  mode: 1 logic, 0 arithmetic.
- req_c_in  in  1  carry into nibble 0 (active-high, added).
- req_use_acc  in  1  only with ULA_SEQ_ACC_EN: use accumulator as A.
- rsp_valid  out  1  response valid; high only in DONE.
- rsp_ready  in  1  response accepted.
- rsp_result  out  WIDTH  assembled F.
- rsp_c_out  out  1  carry out of the last nibble.
- rsp_a_eq_b  out  1  AND of every nibble's a_eq_b.
- busy  out  1  high in RUN or DONE.
- alu_a, alu_b  out  4  nibble operands to ALU.
- alu_s  out  4  function select to ALU.
- alu_m  out  1  mode to ALU.
- alu_c_in  out  1  carry to ALU.
- alu_f  in  4  ALU result.
- alu_c_out  in  1  ALU carry out.
- alu_a_eq_b  in  1  ALU nibble equality.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state: IDLE.
- IDLE → RUN on req_valid && req_ready.
  - Latch A, B, s, m, c_in.
  - Nibble index ← 0; carry register ← req_c_in; equality register ← 1.
- RUN, combinational outputs:
  - alu_a/alu_b = latched A/B bits [4·idx+3 : 4·idx].
  - alu_s, alu_m = latched values; alu_c_in = carry register.
- RUN, each edge:
  - result nibble idx ← alu_f.
  - carry register ← alu_c_out.
  - equality register ← equality register & alu_a_eq_b.
  - idx increments.
  - After idx = NIBBLES−1, go to DONE.
- Carry chains for both modes. In logic mode the ALU returns c_out = 0, so rsp_c_out = 0.
- DONE → IDLE on rsp_ready. rsp_result, rsp_c_out and rsp_a_eq_b hold stable while rsp_valid is high.
- Outside RUN, alu_a, alu_b, alu_s, alu_m and alu_c_in drive 0.
- req_valid outside IDLE is ignored; it is not queued.
- Result semantics are the nibble-chained composition of the ALU function. For S=1001 and S=0110 this equals true WIDTH-bit A+B+cin and A+~B+cin.

## Timing
- Reset values: req_ready=1, rsp_valid=0, busy=0, rsp_result=0, rsp_c_out=0, rsp_a_eq_b=0, alu_* outputs = 0, idx=0.
- Request accepted at edge k. RUN occupies cycles k+1 … k+NIBBLES. rsp_valid is high from cycle k+NIBBLES+1.
- Minimum issue interval: NIBBLES+2 cycles with rsp_ready held high.
- Response handshake completes at an edge with rsp_valid && rsp_ready. req_ready rises the following cycle; there is no same-cycle response-to-request bypass.
- rst high at any edge, including mid-RUN or in DONE:
  - Abort; next cycle is IDLE with reset values.
  - No response is issued for the aborted operation.
- The ALU path is combinational. alu_* outputs to alu_f/alu_c_out must settle within one cycle.

## Configuration
- ULA_SEQ_ACC_EN defined:
  - Adds port req_use_acc and a WIDTH-bit accumulator register, reset to 0.
  - The accumulator is loaded with the assembled result on the RUN→DONE edge.
  - If req_use_acc=1 at accept, the accumulator value is latched as A instead of req_a.
- ULA_SEQ_ACC_EN undefined: no req_use_acc port, no accumulator; A is always req_a.

## Test plan
- Add: m=0, s=1001, A=0x1234, B=0x0FFF, cin=0 → rsp_result=0x2233, rsp_c_out=0, rsp_a_eq_b=0; rsp_valid exactly 5 cycles after the accept edge (WIDTH=16).
- Carry ripple: s=1001, A=0xFFFF, B=0x0001, cin=0 → result 0x0000, c_out=1. Check alu_c_in=1 on nibbles 1–3.
- Subtract: s=0110, cin=1, A=0x5000, B=0x0001 → result 0x4FFF, c_out=1.
- Logic: m=1, s=0110, A=B=0xA5A5 → result 0x0000, a_eq_b=1, c_out=0.
- Backpressure and reset:
  - Hold rsp_ready=0 for 5 cycles in DONE → result stable, req_ready=0, a second req_valid is ignored.
  - Assert rst during nibble 2 → next cycle IDLE, rsp_valid=0, req_ready=1.
- ULA_SEQ_ACC_EN:
  - Run add 0x0010+0x0005 → accumulator = 0x0015.
  - Then req_use_acc=1, s=1001, B=0x0001 → result 0x0016.
